// File: rtl/portal_pkg.sv
// Shared portal pipe constants, header layout and the length-clamp helper.
// Used by the pipe serializer and by the M2P/P2M encoders and deserializer.
package portal_pkg;

  localparam int PIPE_WIDTH = 128;
  localparam int WORD_WIDTH = 32;
  localparam int PIPE_WORDS = PIPE_WIDTH / WORD_WIDTH;

  // Header word field positions
  localparam int METHOD_LSB = 16;
  localparam int LEN_LSB    = 0;
  localparam int LEN_BITS   = 16;

  // Width of a word count that can hold 1..PIPE_WORDS
  localparam int NW_BITS = $clog2(PIPE_WORDS + 1);

  typedef struct packed {
    logic [15:0] method;
    logic [15:0] len;
  } portal_hdr_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  typedef struct packed {
    logic [NW_BITS-1:0] nwords;
    logic               err;
  } clamp_t;

  // Map the header length to the number of words actually emitted.
  // A zero length still sends the header; oversize lengths are cut to a
  // full pipe. Both cases are flagged so the caller can count them.
  function automatic clamp_t clamp_len(input logic [LEN_BITS-1:0] len);
    clamp_t r;
    if (len == LEN_BITS'(0)) begin
      r.nwords = NW_BITS'(1);
      r.err    = 1'b1;
    end else if (len > LEN_BITS'(PIPE_WORDS)) begin
      r.nwords = NW_BITS'(PIPE_WORDS);
      r.err    = 1'b1;
    end else begin
      r.nwords = len[NW_BITS-1:0];
      r.err    = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/portal_pipe_serializer.sv
// Transmit end of the 128-bit portal pipe: takes one pipe message per
// handshake and emits it as 32-bit words, header (lowest word) first.
// A new message may be accepted on the final-word cycle for gap-free output.
module portal_pipe_serializer
  import portal_pkg::*;
#(
  parameter int MAX_WORDS = PIPE_WORDS
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          in_enq__ENA,
  input  logic [MAX_WORDS*WORD_WIDTH-1:0] in_enq_v,
  output logic                          in_enq__RDY,
  output logic                          out_enq__ENA,
  output logic [WORD_WIDTH-1:0]         out_enq_v,
  output logic                          out_enq_last,
  input  logic                          out_enq__RDY,
  output logic [15:0]                   err_count
);

  localparam int IDX_BITS = $clog2(MAX_WORDS);

  ser_state_t                            state_r;
  ser_state_t                            state_nxt_s;
  logic [MAX_WORDS-1:0][WORD_WIDTH-1:0]  buffer_r;
  logic [IDX_BITS-1:0]                   index_r;
  logic [NW_BITS-1:0]                    nwords_r;
  logic [15:0]                           err_count_r;

  logic   busy_s;
  logic   last_s;
  logic   out_ena_s;
  logic   in_rdy_s;
  logic   accept_s;
  clamp_t clamp_s;

  assign clamp_s = clamp_len(in_enq_v[LEN_LSB +: LEN_BITS]);

  // Handshake decode: word transfer, last-word flag and input readiness
  always_comb begin
    busy_s    = (state_r == ST_SEND);
    last_s    = (NW_BITS'(index_r) == (nwords_r - NW_BITS'(1)));
    out_ena_s = busy_s & out_enq__RDY;
    // Ready while idle, or when the final word leaves this cycle
    in_rdy_s  = ~busy_s | (out_ena_s & last_s);
    accept_s  = in_enq__ENA & in_rdy_s;
  end

  // Next-state: enter SEND on accept, leave only after the last word with no refill
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (out_ena_s & last_s & ~accept_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Message buffer, word count and word index
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      buffer_r <= {(MAX_WORDS*WORD_WIDTH){1'b0}};
      nwords_r <= {NW_BITS{1'b0}};
      index_r  <= {IDX_BITS{1'b0}};
    end else if (accept_s) begin
      buffer_r <= in_enq_v;
      nwords_r <= clamp_s.nwords;
      index_r  <= {IDX_BITS{1'b0}};
    end else if (out_ena_s) begin
      if (last_s) begin
        index_r <= {IDX_BITS{1'b0}};
      end else begin
        index_r <= index_r + IDX_BITS'(1);
      end
    end
  end

  // Saturating count of messages whose length field had to be clamped
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_count_r <= 16'h0000;
    end else if (accept_s & clamp_s.err & (err_count_r != 16'hFFFF)) begin
      err_count_r <= err_count_r + 16'h0001;
    end
  end

  // Word data and last flag come straight from the buffer/index registers
  assign out_enq_v    = buffer_r[index_r];
  assign out_enq_last = last_s;
  assign out_enq__ENA = out_ena_s;
  assign in_enq__RDY  = in_rdy_s;
  assign err_count    = err_count_r;

endmodule

// File: tb/tb_portal_pipe_serializer.sv
// Self-checking bench for portal_pipe_serializer: table-driven messages with a
// word scoreboard, plus stall, back-to-back and mid-message reset sequences.
module tb_portal_pipe_serializer;

  logic         CLK;
  logic         RST;
  logic         in_ena;
  logic [127:0] in_v;
  logic         in_rdy;
  logic         out_ena;
  logic [31:0]  out_v;
  logic         out_last;
  logic         out_rdy;
  logic [15:0]  err_count;

  typedef struct packed {
    logic [31:0] v;
    logic        last;
  } exp_t;

  typedef struct {
    logic [127:0] msg;
    int           nw;
    logic [15:0]  err;
  } vec_t;

  exp_t q[$];
  int   checks;
  int   failures;
  int   neg_cnt;
  int   ena_cnt;
  int   last_ena_neg;

  portal_pipe_serializer dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_enq__ENA  (in_ena),
    .in_enq_v     (in_v),
    .in_enq__RDY  (in_rdy),
    .out_enq__ENA (out_ena),
    .out_enq_v    (out_v),
    .out_enq_last (out_last),
    .out_enq__RDY (out_rdy),
    .err_count    (err_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one message once ready; returns 1ns after the accepting edge
  task automatic enq(input logic [127:0] m, input int nw);
    int   guard;
    exp_t e;
    guard = 0;
    while (!in_rdy && guard < 100) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (guard >= 100) begin
      chk("enq_ready_timeout", 32'd0, 32'd1);
    end else begin
      for (int i = 0; i < nw; i++) begin
        e.v    = m[32*i +: 32];
        e.last = (i == nw - 1);
        q.push_back(e);
      end
      in_ena = 1'b1;
      in_v   = m;
      @(posedge CLK); #1;
      in_ena = 1'b0;
      in_v   = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Wait (bounded) until every expected word has been seen
  task automatic drain(input string name);
    int guard;
    guard = 0;
    do begin
      @(posedge CLK); #1;
      guard++;
    end while (q.size() > 0 && guard < 60);
    chk(name, q.size(), 32'd0);
  endtask

  // Output monitor: scoreboard compare, stall hold and ENA/RDY rule
  task automatic monitor();
    logic [31:0] pv;
    logic        pl;
    bit          pst;
    exp_t        e;
    pst = 1'b0;
    pv  = 32'd0;
    pl  = 1'b0;
    forever begin
      @(negedge CLK);
      neg_cnt++;
      if (RST) begin
        pst = 1'b0;
      end else begin
        if (pst) begin
          chk("stall_hold_v", out_v, pv);
          chk("stall_hold_last", {31'd0, out_last}, {31'd0, pl});
        end
        if (!out_rdy && q.size() > 0) begin
          chk("ena_without_rdy", {31'd0, out_ena}, 32'd0);
        end
        if (out_ena) begin
          ena_cnt++;
          last_ena_neg = neg_cnt;
          if (q.size() == 0) begin
            chk("unexpected_word", out_v, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("word_v", out_v, e.v);
            chk("word_last", {31'd0, out_last}, {31'd0, e.last});
          end
        end
        pst = (!out_rdy && q.size() > 0);
        pv  = out_v;
        pl  = out_last;
      end
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   s_neg;
    int   s_ena;

    checks       = 0;
    failures     = 0;
    neg_cnt      = 0;
    ena_cnt      = 0;
    last_ena_neg = 0;
    RST          = 1'b1;
    in_ena       = 1'b0;
    in_v         = 128'd0;
    out_rdy      = 1'b1;

    vecs[0] = '{msg: {64'd0, 32'h12345678, 16'd0, 16'd2}, nw: 2, err: 16'd0};
    vecs[1] = '{msg: {32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE, 16'h00A5, 16'd1}, nw: 1, err: 16'd0};
    vecs[2] = '{msg: {32'h44444444, 32'h33333333, 32'h22222222, 16'h0003, 16'd3}, nw: 3, err: 16'd0};
    vecs[3] = '{msg: {32'h77777777, 32'h66666666, 32'h55555555, 16'h0007, 16'd0}, nw: 1, err: 16'd1};
    vecs[4] = '{msg: {32'hA4A4A4A4, 32'hA3A3A3A3, 32'hA2A2A2A2, 16'h0009, 16'd7}, nw: 4, err: 16'd2};
    vecs[5] = '{msg: {32'hB4B4B4B4, 32'hB3B3B3B3, 32'hB2B2B2B2, 16'h000B, 16'hFFFF}, nw: 4, err: 16'd3};

    fork
      monitor();
    join_none

    // Reset values while RST is held, then after release
    #3;
    chk("rst_out_ena", {31'd0, out_ena}, 32'd0);
    chk("rst_out_v", out_v, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("idle_in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("idle_out_ena", {31'd0, out_ena}, 32'd0);

    // Table-driven messages with downstream always ready
    for (int k = 0; k < 6; k++) begin
      enq(vecs[k].msg, vecs[k].nw);
      @(negedge CLK);
      chk($sformatf("latency_v%0d", k), {31'd0, out_ena}, 32'd1);
      drain($sformatf("drain_v%0d", k));
      chk($sformatf("err_v%0d", k), {16'd0, err_count}, {16'd0, vecs[k].err});
    end

    // Four-word message with downstream ready toggling 1,0,1,0,...
    enq({32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 16'h0042, 16'd4}, 4);
    for (int i = 0; i < 40 && q.size() > 0; i++) begin
      out_rdy = (i % 2 == 0);
      @(posedge CLK); #1;
    end
    out_rdy = 1'b1;
    drain("drain_toggle");
    chk("err_toggle", {16'd0, err_count}, 32'd3);

    // Back-to-back: second message offered on the first one's last-word cycle
    s_neg = neg_cnt;
    s_ena = ena_cnt;
    enq({64'd0, 32'hE1E1E1E1, 16'h0010, 16'd2}, 2);
    @(posedge CLK); #1;
    chk("b2b_in_rdy_on_last", {31'd0, in_rdy}, 32'd1);
    chk("b2b_out_last", {31'd0, out_last}, 32'd1);
    enq({64'd0, 32'hF1F1F1F1, 16'h0011, 16'd2}, 2);
    drain("drain_b2b");
    chk("b2b_word_count", ena_cnt - s_ena, 32'd4);
    chk("b2b_no_bubble", last_ena_neg - s_neg, 32'd5);

    // Asynchronous reset after the header of a four-word message
    enq({32'hC4C4C4C4, 32'hC3C3C3C3, 32'hC2C2C2C2, 16'h0020, 16'd4}, 4);
    @(posedge CLK); #3;
    RST = 1'b1;
    #1;
    chk("arst_out_ena", {31'd0, out_ena}, 32'd0);
    chk("arst_out_v", out_v, 32'd0);
    chk("arst_out_last", {31'd0, out_last}, 32'd0);
    chk("arst_err_count", {16'd0, err_count}, 32'd0);
    q.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("arst_in_rdy", {31'd0, in_rdy}, 32'd1);
    s_ena = ena_cnt;
    repeat (8) begin
      @(posedge CLK); #1;
    end
    chk("arst_no_trailing_words", ena_cnt - s_ena, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
